// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and defaults for the systolic array slice.
// Weight-loader states and the weight-to-psum widening helper.
package tpu_pkg;

  localparam int DEF_ARRAY_DIM  = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    FILL,
    WAIT,
    LOAD,
    DONE
  } wl_state_t;

  function automatic logic [DEF_ACC_WIDTH-1:0] zext_w(
    input logic [DEF_DATA_WIDTH-1:0] w
  );
    return DEF_ACC_WIDTH'(w);
  endfunction

endpackage

// File: rtl/weight_row_buf.sv
// weight_row_buf: N-row staging register file for weight rows.
// One write port, one async read port, synchronous clear.
module weight_row_buf #(
  parameter  int ROWS  = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ROWS];

  // row storage; clear beats write so a flushed row never lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: stages N weight rows, then streams them down
// the psum chains bottom row first so all PEs capture together.
module weight_load_ctrl
  import tpu_pkg::*;
#(
  parameter int ARRAY_DIM  = DEF_ARRAY_DIM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] w_row,
  input  logic                           flush,
  input  logic                           array_idle,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_top,
  output logic                           en_weight_pass,
  output logic [ARRAY_DIM-1:0]           en_weight_capture,
  output logic                           load_busy,
  output logic                           load_done
);

  localparam int CW = $clog2(ARRAY_DIM);
  localparam int RW = ARRAY_DIM * DATA_WIDTH;
  localparam int PW = ARRAY_DIM * ACC_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(ARRAY_DIM - 1);

  wl_state_t state_q, state_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [PW-1:0] psum_q, psum_d;
  logic [ARRAY_DIM-1:0] cap_q, cap_d;
  logic pass_q, pass_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic          we;
  logic [CW-1:0] raddr;
  logic [RW-1:0] rdata;

  assign w_ready = (state_q == FILL);
  assign we      = w_valid && w_ready && !flush;
  // outputs are registered, so read the row for the coming k
  assign raddr   = LAST - k_d;

  weight_row_buf #(
    .ROWS  (ARRAY_DIM),
    .WIDTH (RW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .we_i    (we),
    .waddr_i (row_cnt_q),
    .wdata_i (w_row),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // next state and counters; flush overrides every state
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    k_d       = k_q;
    if (flush) begin
      state_d   = FILL;
      row_cnt_d = '0;
      k_d       = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (w_valid) begin
            if (row_cnt_q == LAST) begin
              state_d   = WAIT;
              row_cnt_d = '0;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
        WAIT: begin
          if (array_idle) begin
            state_d = LOAD;
            k_d     = '0;
          end
        end
        LOAD: begin
          if (k_q == LAST) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DONE:    state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // output values for the upcoming cycle, decoded from state_d/k_d
  always_comb begin
    psum_d = '0;
    cap_d  = '0;
    pass_d = (state_d == LOAD);
    busy_d = (state_d == WAIT) || (state_d == LOAD);
    done_d = (state_d == DONE);
    if (state_d == LOAD) begin
      for (int c = 0; c < ARRAY_DIM; c++) begin
        psum_d[c*ACC_WIDTH +: ACC_WIDTH] =
          zext_w(rdata[c*DATA_WIDTH +: DATA_WIDTH]);
      end
      if (k_d == LAST) cap_d = '1;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      row_cnt_q <= '0;
      k_q       <= '0;
      psum_q    <= '0;
      cap_q     <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      k_q       <= k_d;
      psum_q    <= psum_d;
      cap_q     <= cap_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign psum_top          = psum_q;
  assign en_weight_pass    = pass_q;
  assign en_weight_capture = cap_q;
  assign load_busy         = busy_q;
  assign load_done         = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: scoreboard bench for weight_load_ctrl,
// with a column-chain PE model that latches the streamed weights.
module tb_weight_load_ctrl;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int RW  = N * DW;
  localparam int PW  = N * AW;

  logic          clk;
  logic          rst_n;
  logic          w_valid;
  logic          w_ready;
  logic [RW-1:0] w_row;
  logic          flush;
  logic          array_idle;
  logic [PW-1:0] psum_top;
  logic          en_weight_pass;
  logic [N-1:0]  en_weight_capture;
  logic          load_busy;
  logic          load_done;

  int tests = 0;
  int fails = 0;

  logic [RW-1:0] sb [$];

  logic [AW-1:0] pass_reg [N][N];
  logic [DW-1:0] pe_w     [N][N];

  weight_load_ctrl #(
    .ARRAY_DIM  (N),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .w_valid           (w_valid),
    .w_ready           (w_ready),
    .w_row             (w_row),
    .flush             (flush),
    .array_idle        (array_idle),
    .psum_top          (psum_top),
    .en_weight_pass    (en_weight_pass),
    .en_weight_capture (en_weight_capture),
    .load_busy         (load_busy),
    .load_done         (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ext_row(input logic [RW-1:0] r);
    logic [PW-1:0] p;
    p = '0;
    for (int c = 0; c < N; c++) p[c*AW +: DW] = r[c*DW +: DW];
    return p;
  endfunction

  // PE array model: psum chain per column, per-row capture
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (en_weight_pass) pass_reg[0][c] <= psum_top[c*AW +: AW];
      if (en_weight_capture[0]) pe_w[0][c] <= psum_top[c*AW +: DW];
      for (int r = 1; r < N; r++) begin
        if (en_weight_pass) pass_reg[r][c] <= pass_reg[r-1][c];
        if (en_weight_capture[r]) pe_w[r][c] <= pass_reg[r-1][c][DW-1:0];
      end
    end
  end

  // scoreboard: every pass cycle must carry the next expected row
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (en_weight_pass) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL psum_sb: pass with empty queue, psum=%h", psum_top);
        end else begin
          logic [PW-1:0] e;
          e = ext_row(sb.pop_front());
          if (psum_top !== e) begin
            fails++;
            $display("FAIL psum_sb: psum=%h want %h", psum_top, e);
          end
        end
      end else if (psum_top !== '0) begin
        fails++;
        $display("FAIL psum_idle: psum=%h want 0", psum_top);
      end
    end
  end

  task automatic send_row(input logic [RW-1:0] row);
    int n;
    n = 0;
    w_valid = 1'b1;
    w_row   = row;
    @(negedge clk);
    while (!w_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!w_ready) begin
      fails++;
      $display("FAIL send_row: w_ready=%b want 1 (timeout)", w_ready);
    end else begin
      sb.push_front(row);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic test_load(input string nm, input logic [RW-1:0] rows [N],
                           input int idle_wait, input bit junk);
    int w;
    logic [N+3:0] e;
    logic [N+3:0] g;
    w = idle_wait + 1;
    array_idle = (idle_wait == 0);
    for (int r = 0; r < N; r++) send_row(rows[r]);
    for (int cyc = 1; cyc <= w + N + 2; cyc++) begin
      if (idle_wait > 0 && cyc == idle_wait + 1) array_idle = 1'b1;
      w_valid = junk && (cyc <= w + N + 1);
      if (junk) w_row = RW'($urandom);
      if (cyc <= w)
        e = {2'b10, {N{1'b0}}, 2'b00};
      else if (cyc <= w + N)
        e = {2'b11, (cyc == w + N) ? {N{1'b1}} : {N{1'b0}}, 2'b00};
      else if (cyc == w + N + 1)
        e = {2'b00, {N{1'b0}}, 2'b10};
      else
        e = {2'b00, {N{1'b0}}, 2'b01};
      @(negedge clk);
      g = {load_busy, en_weight_pass, en_weight_capture, load_done, w_ready};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s_ctl_c%0d: busy,pass,cap,done,rdy=%b want %b",
                 nm, cyc, g, e);
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_sb_left: %0d rows left want 0", nm, sb.size());
    end
    // identity activation: one-hot row r reproduces weight row r
    for (int r = 0; r < N; r++) begin
      logic [RW-1:0] got;
      got = '0;
      for (int c = 0; c < N; c++)
        for (int rr = 0; rr < N; rr++)
          if (rr == r) got[c*DW +: DW] = got[c*DW +: DW] + pe_w[rr][c];
      tests++;
      if (got !== rows[r]) begin
        fails++;
        $display("FAIL %s_pe_row%0d: psum=%h want %h", nm, r, got, rows[r]);
      end
    end
  endtask

  task automatic test_reset;
    logic [N+4:0] g;
    logic [RW-1:0] r;
    @(negedge clk);
    g = {load_busy, en_weight_pass, en_weight_capture, load_done, w_ready,
         psum_top == '0};
    tests++;
    if (g !== {2'b00, {N{1'b0}}, 3'b011}) begin
      fails++;
      $display("FAIL reset_outs: %b want %b", g, {2'b00, {N{1'b0}}, 3'b011});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    array_idle = 1'b1;
    r = 32'hdeadbeef;
    send_row(r);
    r = 32'hcafef00d;
    send_row(r);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    g = {load_busy, en_weight_pass, en_weight_capture, load_done, w_ready,
         psum_top == '0};
    tests++;
    if (g !== {2'b00, {N{1'b0}}, 3'b011}) begin
      fails++;
      $display("FAIL reset_mid: %b want %b", g, {2'b00, {N{1'b0}}, 3'b011});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_flush(input logic [RW-1:0] ra [N],
                            input logic [RW-1:0] rb [N]);
    logic [N:0] g;
    array_idle = 1'b1;
    for (int r = 0; r < N; r++) send_row(ra[r]);
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    g = {en_weight_pass, en_weight_capture};
    tests++;
    if (g !== {1'b1, {N{1'b0}}}) begin
      fails++;
      $display("FAIL flush_at_k1: pass,cap=%b want %b", g, {1'b1, {N{1'b0}}});
    end
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      logic [N+3:0] h;
      @(negedge clk);
      h = {load_busy, en_weight_pass, en_weight_capture, load_done, w_ready};
      tests++;
      if (h !== {2'b00, {N{1'b0}}, 2'b01}) begin
        fails++;
        $display("FAIL flush_after_c%0d: %b want %b", i, h,
                 {2'b00, {N{1'b0}}, 2'b01});
      end
      @(posedge clk); #1;
    end
    test_load("reload", rb, 0, 1'b0);
  endtask

  task automatic test_flush_last(input logic [RW-1:0] rb [N]);
    logic [1:0] g;
    array_idle = 1'b1;
    for (int r = 0; r < N - 1; r++) send_row(RW'($urandom));
    w_valid = 1'b1;
    w_row   = RW'($urandom);
    flush   = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    flush   = 1'b0;
    sb.delete();
    @(negedge clk);
    g = {load_busy, w_ready};
    tests++;
    if (g !== 2'b01) begin
      fails++;
      $display("FAIL flush_last: busy,rdy=%b want 01", g);
    end
    @(posedge clk); #1;
    test_load("after_fl", rb, 0, 1'b0);
  endtask

  initial begin
    logic [RW-1:0] ra [N];
    logic [RW-1:0] rb [N];
    logic [RW-1:0] rc [N];
    logic [RW-1:0] rd [N];
    logic [RW-1:0] re [N];
    logic [RW-1:0] rf [N];
    rst_n      = 1'b0;
    w_valid    = 1'b0;
    w_row      = '0;
    flush      = 1'b0;
    array_idle = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ra[r][c*DW +: DW] = DW'(16 * r + c + 1);
      rb[r] = RW'($urandom);
      rc[r] = RW'($urandom);
      rd[r] = RW'($urandom);
      re[r] = RW'($urandom);
      rf[r] = RW'($urandom);
    end
    test_reset();
    test_load("basic", ra, 0, 1'b0);
    test_load("idle_wait", rb, 10, 1'b0);
    test_flush(rc, rd);
    test_flush_last(re);
    test_load("busy_junk", rf, 3, 1'b1);
    test_load("back2back", ra, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
